// File: rtl/bit_diff_encoder.sv
// Serially builds a WIDTH-bit word whose (ones - zeros) equals a signed target.
// go/ready accept on the input side, valid/ready with backpressure on the output side.
module bit_diff_encoder #(
    parameter int WIDTH       = 32,
    parameter int DIFF_WIDTH  = $clog2(2*WIDTH+1),
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [DIFF_WIDTH-1:0]  target,
    output logic                   ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] word_count
);

    localparam int OW = DIFF_WIDTH - 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIFF_WIDTH:0]   WIDTH_EXT = (DIFF_WIDTH+1)'(WIDTH);
    localparam logic [DIFF_WIDTH-1:0] MAX_SUM   = DIFF_WIDTH'(2*WIDTH);
    localparam logic [CW-1:0]         LAST_BIT  = CW'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

    state_t                 state_q;
    logic [OW-1:0]          ones_q;
    logic [WIDTH-1:0]       shift_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [WIDTH-1:0]       data_q;
    logic                   valid_q;
    logic                   error_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic [DIFF_WIDTH:0]    sum_d;
    logic                   tgt_ok_d;
    logic                   accept_d;
    logic [WIDTH-1:0]       shift_d;

    // sum = target + WIDTH, sign-extended by one bit so it cannot overflow.
    // Non-negative, at most 2*WIDTH and even means the target is reachable.
    assign sum_d    = {target[DIFF_WIDTH-1], target} + WIDTH_EXT;
    assign tgt_ok_d = !sum_d[DIFF_WIDTH] && (sum_d[DIFF_WIDTH-1:0] <= MAX_SUM) && !sum_d[0];
    assign ready    = (state_q == IDLE) || (state_q == HOLD && data_out_ready);
    assign accept_d = go && ready;
    assign shift_d  = {(ones_q != '0), shift_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                BUILD: begin
                    shift_q   <= shift_d;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (ones_q != '0) ones_q <= ones_q - OW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        data_q  <= shift_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (data_out_ready) begin
                        count_q <= count_q + COUNT_WIDTH'(1);
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
            // Accept may coincide with the HOLD handshake; it overrides the IDLE return.
            if (accept_d) begin
                if (tgt_ok_d) begin
                    ones_q    <= sum_d[DIFF_WIDTH-1:1];
                    shift_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= BUILD;
                end else begin
                    error_q <= 1'b1;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign error          = error_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_bit_diff_encoder.sv
// Directed bench for bit_diff_encoder: vector table plus backpressure, reset and wrap sequences.
module tb_bit_diff_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [6:0]  target = '0;
    logic        ready;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready = 1'b0;
    logic        error;
    logic [15:0] word_count;

    // Small instance so the counter wrap runs in a few hundred cycles.
    logic        go_s = 1'b0;
    logic [3:0]  target_s = '0;
    logic        ready_s;
    logic [3:0]  data_out_s;
    logic        valid_s;
    logic        dor_s = 1'b0;
    logic        error_s;
    logic [3:0]  wc_s;

    bit_diff_encoder dut (
        .clk(clk), .rst_n(rst_n), .go(go), .target(target), .ready(ready),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .error(error), .word_count(word_count)
    );

    bit_diff_encoder #(.WIDTH(4), .COUNT_WIDTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .go(go_s), .target(target_s), .ready(ready_s),
        .data_out(data_out_s), .data_out_valid(valid_s),
        .data_out_ready(dor_s), .error(error_s), .word_count(wc_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tgt;
        bit          err;
        logic [31:0] word;
    } vec_t;

    vec_t        vecs [12];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_wc  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; checks the 32-edge build latency and the word.
    task automatic wait_word(input logic [31:0] word, input int tgt);
        bit early = 1'b0;
        bit rdy_hi = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i < 32 && data_out_valid) early = 1'b1;
            if (i < 32 && ready) rdy_hi = 1'b1;
        end
        chk("valid_early", {63'd0, early}, 64'd0);
        chk("ready_in_build", {63'd0, rdy_hi}, 64'd0);
        chk("valid_at_latency", {63'd0, data_out_valid}, 64'd1);
        chk("data_out", {32'd0, data_out}, {32'd0, word});
        chk("round_trip_diff", 64'(2*$countones(data_out) - 32), 64'(tgt));
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] tv;
        tv = v.tgt;
        chk("ready_before_go", {63'd0, ready}, 64'd1);
        go = 1'b1;
        target = tv[6:0];
        step();
        go = 1'b0;
        if (v.err) begin
            chk("error_pulse", {63'd0, error}, 64'd1);
            chk("err_no_valid", {63'd0, data_out_valid}, 64'd0);
            chk("err_ready", {63'd0, ready}, 64'd1);
            step();
            chk("error_one_cycle", {63'd0, error}, 64'd0);
            chk("err_wc_same", {48'd0, word_count}, {48'd0, exp_wc});
        end else begin
            wait_word(v.word, v.tgt);
            data_out_ready = 1'b1;
            step();
            data_out_ready = 1'b0;
            exp_wc++;
            chk("hs_valid_drop", {63'd0, data_out_valid}, 64'd0);
            chk("hs_wc", {48'd0, word_count}, {48'd0, exp_wc});
            chk("hs_idle_ready", {63'd0, ready}, 64'd1);
            chk("data_retained", {32'd0, data_out}, {32'd0, v.word});
        end
    endtask

    initial begin
        vecs[0]  = '{0,   1'b0, 32'h0000FFFF};
        vecs[1]  = '{32,  1'b0, 32'hFFFFFFFF};
        vecs[2]  = '{-32, 1'b0, 32'h00000000};
        vecs[3]  = '{-30, 1'b0, 32'h00000001};
        vecs[4]  = '{30,  1'b0, 32'h7FFFFFFF};
        vecs[5]  = '{5,   1'b1, 32'h0};
        vecs[6]  = '{40,  1'b1, 32'h0};
        vecs[7]  = '{-33, 1'b1, 32'h0};
        vecs[8]  = '{-34, 1'b1, 32'h0};
        vecs[9]  = '{-64, 1'b1, 32'h0};
        vecs[10] = '{63,  1'b1, 32'h0};
        vecs[11] = '{-2,  1'b0, 32'h00007FFF};

        #12;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("rst_data", {32'd0, data_out}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_wc", {48'd0, word_count}, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure on target=2, then handshake and new accept in the same cycle.
        go = 1'b1;
        target = 7'd2;
        step();
        go = 1'b0;
        wait_word(32'h0001FFFF, 2);
        begin
            bit unstable = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (data_out !== 32'h0001FFFF || data_out_valid !== 1'b1 || ready !== 1'b0)
                    unstable = 1'b1;
            end
            chk("bp_hold_stable", {63'd0, unstable}, 64'd0);
        end
        data_out_ready = 1'b1;
        go = 1'b1;
        target = 7'h7E;
        #1;
        chk("bp_ready_comb", {63'd0, ready}, 64'd1);
        step();
        go = 1'b0;
        data_out_ready = 1'b0;
        exp_wc++;
        chk("bp_wc", {48'd0, word_count}, {48'd0, exp_wc});
        chk("bp_valid_drop", {63'd0, data_out_valid}, 64'd0);
        chk("bp_rebuild_ready", {63'd0, ready}, 64'd0);
        wait_word(32'h00007FFF, -2);
        data_out_ready = 1'b1;
        step();
        data_out_ready = 1'b0;
        exp_wc++;
        chk("bp_wc2", {48'd0, word_count}, {48'd0, exp_wc});

        // Asynchronous reset in the middle of BUILD.
        go = 1'b1;
        target = 7'd0;
        step();
        go = 1'b0;
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {63'd0, ready}, 64'd1);
        chk("arst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("arst_data", {32'd0, data_out}, 64'd0);
        chk("arst_error", {63'd0, error}, 64'd0);
        chk("arst_wc", {48'd0, word_count}, 64'd0);
        #3 rst_n = 1'b1;
        begin
            bit saw = 1'b0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (data_out_valid) saw = 1'b1;
            end
            chk("no_valid_after_rst", {63'd0, saw}, 64'd0);
        end

        // Counter wrap on the 4-bit instance: back-to-back words, ready tied high.
        begin
            int  hs = 0;
            bit  prev_v = 1'b0;
            bit  bad_word = 1'b0;
            bit  done = 1'b0;
            go_s = 1'b1;
            target_s = 4'd0;
            dor_s = 1'b1;
            for (int i = 0; i < 300 && !done; i++) begin
                step();
                if (prev_v) begin
                    hs++;
                    if (hs == 16) chk("wrap_zero", {60'd0, wc_s}, 64'd0);
                    if (hs == 17) begin
                        chk("wrap_one", {60'd0, wc_s}, 64'd1);
                        done = 1'b1;
                    end
                end
                if (valid_s && data_out_s !== 4'b0011) bad_word = 1'b1;
                prev_v = valid_s;
            end
            go_s = 1'b0;
            chk("wrap_reached", {63'd0, done}, 64'd1);
            chk("wrap_words", {63'd0, bad_word}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
